// File: rtl/cc_transition_sequencer.sv
// cc_transition_sequencer
// Drives the matrix background/point banks with one complete transition screen
// per accepted start: instant load or top-down row wipe, then a timed hold and
// a one-cycle completion pulse. Abort blanks the screen and returns to idle.
module cc_transition_sequencer #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int SEL_W       = 3,
    parameter int STEP_CYCLES = 2_500_000,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic                  TRANSITION_CLOCK_50,
    input  logic                  TRANSITION_RESET_InHigh,
    input  logic                  TRANSITION_START_InHigh,
    input  logic                  TRANSITION_ABORT_InHigh,
    input  logic [SEL_W-1:0]      TRANSITION_SEL,
    input  logic                  TRANSITION_MODE,
    output logic [ROWS*COLS-1:0]  TRANSITION_BACKG,
    output logic [ROWS*COLS-1:0]  TRANSITION_POINT,
    output logic                  TRANSITION_BUSY,
    output logic                  TRANSITION_DONE
);

    localparam int MAX_CYC = (STEP_CYCLES > HOLD_CYCLES) ? STEP_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [ROW_W-1:0] ROW_TOP   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO  = ROW_W'(32'd0);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(32'd1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WIPE = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                 state_r;
    logic [SEL_W-1:0]       sel_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [ROW_W-1:0]       row_r;
    logic                   wipe_init_r;
    logic [ROWS*COLS-1:0]   backg_r;
    logic [ROWS*COLS-1:0]   point_r;
    logic                   busy_r;
    logic                   done_r;

    // Background ROM: one 8x8 picture per index, row r held in bits [r*8 +: 8].
    function automatic logic [COLS-1:0] rom_backg(input logic [SEL_W-1:0] sel, input int row);
        logic [63:0] pat_s;
        logic [7:0]  byte_s;
        case (int'(sel))
            32'sd0:  pat_s = 64'hDB00_00E0_00E0_0000;  // game-start field
            32'sd1:  pat_s = 64'h0018_3818_1818_3C00;  // digit 1
            32'sd2:  pat_s = 64'h003C_6606_0C30_7E00;  // digit 2
            32'sd3:  pat_s = 64'h003C_660C_0666_3C00;  // digit 3
            32'sd4:  pat_s = 64'h000C_1C2C_4C7E_0C00;  // digit 4
            32'sd5:  pat_s = 64'h007E_7E3C_1818_3C00;  // trophy
            default: pat_s = 64'h0000_0000_0000_0000;
        endcase
        if (row >= 32'sd0 && row < 32'sd8) begin
            byte_s = pat_s[row*32'sd8 +: 8];
        end else begin
            byte_s = 8'h00;
        end
        return COLS'(byte_s);
    endfunction

    // Player-point ROM: only the game-start field places a point (row 0).
    function automatic logic [COLS-1:0] rom_point(input logic [SEL_W-1:0] sel, input int row);
        logic [7:0] byte_s;
        if (int'(sel) == 32'sd0 && row == 32'sd0) begin
            byte_s = 8'h10;
        end else begin
            byte_s = 8'h00;
        end
        return COLS'(byte_s);
    endfunction

    // Sequencer FSM with registered frame, busy and done outputs.
    // BUSY/DONE are decoded from the state one clock late so that BUSY spans
    // the whole load/wipe/hold interval and DONE follows it without overlap.
    // The chosen mode is carried by the state itself (LOAD vs WIPE).
    always_ff @(posedge TRANSITION_CLOCK_50 or posedge TRANSITION_RESET_InHigh) begin
        if (TRANSITION_RESET_InHigh) begin
            state_r     <= ST_IDLE;
            sel_r       <= '0;
            cnt_r       <= CNT_ZERO;
            row_r       <= ROW_ZERO;
            wipe_init_r <= 1'b0;
            backg_r     <= '0;
            point_r     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else if (TRANSITION_ABORT_InHigh) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            row_r       <= ROW_ZERO;
            wipe_init_r <= 1'b0;
            backg_r     <= '0;
            point_r     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r <= (state_r == ST_LOAD) || (state_r == ST_WIPE) || (state_r == ST_HOLD);
            done_r <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (TRANSITION_START_InHigh) begin
                        sel_r       <= TRANSITION_SEL;
                        cnt_r       <= CNT_ZERO;
                        wipe_init_r <= 1'b1;
                        state_r     <= TRANSITION_MODE ? ST_WIPE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    for (int r = 32'sd0; r < ROWS; r++) begin
                        backg_r[r*COLS +: COLS] <= rom_backg(sel_r, r);
                        point_r[r*COLS +: COLS] <= rom_point(sel_r, r);
                    end
                    cnt_r   <= CNT_ZERO;
                    state_r <= ST_HOLD;
                end
                ST_WIPE: begin
                    if (wipe_init_r) begin
                        backg_r     <= '0;
                        point_r     <= '0;
                        row_r       <= ROW_TOP;
                        cnt_r       <= CNT_ZERO;
                        wipe_init_r <= 1'b0;
                    end else if (cnt_r == STEP_LAST) begin
                        backg_r[int'(row_r)*COLS +: COLS] <= rom_backg(sel_r, int'(row_r));
                        point_r[int'(row_r)*COLS +: COLS] <= rom_point(sel_r, int'(row_r));
                        cnt_r <= CNT_ZERO;
                        if (row_r == ROW_ZERO) begin
                            state_r <= ST_HOLD;
                        end else begin
                            row_r <= row_r - ROW_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign TRANSITION_BACKG = backg_r;
    assign TRANSITION_POINT = point_r;
    assign TRANSITION_BUSY  = busy_r;
    assign TRANSITION_DONE  = done_r;

endmodule

// File: tb/tb_cc_transition_sequencer.sv
// Testbench for cc_transition_sequencer: directed vector table, hand-written
// corner sequences and a randomized run against a timeline-level model.
module tb_cc_transition_sequencer;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int SEL_W = 3;
    localparam int STEP  = 4;
    localparam int HOLD  = 10;
    localparam int NREC  = 21;

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [SEL_W-1:0]     sel   = 3'd0;
    logic                 mode  = 1'b0;
    logic [ROWS*COLS-1:0] bg;
    logic [ROWS*COLS-1:0] pt;
    logic                 busy;
    logic                 done;

    cc_transition_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .SEL_W(SEL_W), .STEP_CYCLES(STEP), .HOLD_CYCLES(HOLD)
    ) dut (
        .TRANSITION_CLOCK_50     (clk),
        .TRANSITION_RESET_InHigh (rst),
        .TRANSITION_START_InHigh (start),
        .TRANSITION_ABORT_InHigh (abort),
        .TRANSITION_SEL          (sel),
        .TRANSITION_MODE         (mode),
        .TRANSITION_BACKG        (bg),
        .TRANSITION_POINT        (pt),
        .TRANSITION_BUSY         (busy),
        .TRANSITION_DONE         (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // expected pictures, row r in bits [r*8 +: 8]
    logic [63:0] rom_bg [8];
    logic [63:0] rom_pt [8];

    typedef struct {
        bit          start;
        bit          abort;
        logic [2:0]  sel;
        bit          mode;
        int          rep;
        bit          busy;
        bit          done;
        logic [63:0] bg;
        logic [63:0] pt;
    } vec_t;
    vec_t tbl [NREC];

    // model state: ph = clocks since the accepted start (-1 when idle)
    int          ph = -1;
    int          m_end = 0;
    int          m_sel = 0;
    bit          m_mode = 1'b0;
    logic [63:0] e_bg = 64'h0;
    logic [63:0] e_pt = 64'h0;
    bit          e_busy = 1'b0;
    bit          e_done = 1'b0;
    int          n_print = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit st, input bit ab, input int s, input bit m);
        int          nrows;
        logic [63:0] mask;
        if (ab) begin
            ph   = -1;
            e_bg = 64'h0;
            e_pt = 64'h0;
        end else if (ph == -1 || ph >= m_end + 1) begin
            if (st) begin
                ph     = 0;
                m_sel  = s;
                m_mode = m;
                m_end  = (m ? 1 + ROWS * STEP : 1) + HOLD;
            end else begin
                ph = -1;
            end
        end else begin
            ph++;
        end
        if (ph >= 1) begin
            nrows = m_mode ? (((ph - 1) / STEP < ROWS) ? (ph - 1) / STEP : ROWS) : ROWS;
            mask  = ~(64'hFFFF_FFFF_FFFF_FFFF >> (nrows * 8));
            e_bg  = rom_bg[m_sel] & mask;
            e_pt  = rom_pt[m_sel] & mask;
        end
        e_busy = (ph >= 1) && (ph <= m_end);
        e_done = (ph >= 1) && (ph == m_end + 1);
    endtask

    initial begin
        rom_bg[0] = 64'hDB00_00E0_00E0_0000;
        rom_bg[1] = 64'h0018_3818_1818_3C00;
        rom_bg[2] = 64'h003C_6606_0C30_7E00;
        rom_bg[3] = 64'h003C_660C_0666_3C00;
        rom_bg[4] = 64'h000C_1C2C_4C7E_0C00;
        rom_bg[5] = 64'h007E_7E3C_1818_3C00;
        rom_bg[6] = 64'h0;
        rom_bg[7] = 64'h0;
        for (int i = 0; i < 8; i++) rom_pt[i] = 64'h0;
        rom_pt[0] = 64'h10;

        // {start, abort, sel, mode, clocks, busy, done, backg, point} checked after last clock
        tbl[0]  = '{1'b1, 1'b0, 3'd1, 1'b0, 1,  1'b0, 1'b0, 64'h0, 64'h0};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1,  1'b1, 1'b0, rom_bg[1], 64'h0};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 1'b0, 10, 1'b1, 1'b0, rom_bg[1], 64'h0};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1,  1'b0, 1'b1, rom_bg[1], 64'h0};
        tbl[4]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1,  1'b0, 1'b0, rom_bg[1], 64'h0};
        tbl[5]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1,  1'b0, 1'b0, rom_bg[1], 64'h0};
        tbl[6]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1,  1'b1, 1'b0, 64'h0, 64'h0};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 1'b0, 4,  1'b1, 1'b0, 64'hDB00_0000_0000_0000, 64'h0};
        tbl[8]  = '{1'b0, 1'b0, 3'd0, 1'b0, 27, 1'b1, 1'b0, 64'hDB00_00E0_00E0_0000, 64'h0};
        tbl[9]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1,  1'b1, 1'b0, 64'hDB00_00E0_00E0_0000, 64'h10};
        tbl[10] = '{1'b0, 1'b0, 3'd0, 1'b0, 10, 1'b1, 1'b0, 64'hDB00_00E0_00E0_0000, 64'h10};
        tbl[11] = '{1'b0, 1'b0, 3'd0, 1'b0, 1,  1'b0, 1'b1, 64'hDB00_00E0_00E0_0000, 64'h10};
        tbl[12] = '{1'b1, 1'b0, 3'd0, 1'b0, 1,  1'b0, 1'b0, 64'hDB00_00E0_00E0_0000, 64'h10};
        tbl[13] = '{1'b0, 1'b0, 3'd0, 1'b0, 3,  1'b1, 1'b0, rom_bg[0], 64'h10};
        tbl[14] = '{1'b1, 1'b0, 3'd1, 1'b1, 1,  1'b1, 1'b0, rom_bg[0], 64'h10};
        tbl[15] = '{1'b0, 1'b0, 3'd0, 1'b0, 7,  1'b1, 1'b0, rom_bg[0], 64'h10};
        tbl[16] = '{1'b0, 1'b0, 3'd0, 1'b0, 1,  1'b0, 1'b1, rom_bg[0], 64'h10};
        tbl[17] = '{1'b1, 1'b0, 3'd1, 1'b1, 1,  1'b0, 1'b0, rom_bg[0], 64'h10};
        tbl[18] = '{1'b0, 1'b0, 3'd0, 1'b0, 18, 1'b1, 1'b0, 64'h0018_3818_0000_0000, 64'h0};
        tbl[19] = '{1'b0, 1'b1, 3'd0, 1'b0, 1,  1'b0, 1'b0, 64'h0, 64'h0};
        tbl[20] = '{1'b0, 1'b0, 3'd0, 1'b0, 45, 1'b0, 1'b0, 64'h0, 64'h0};

        // reset, then idle frame must stay blank
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("reset_backg", bg, 64'h0);
            check("reset_point", pt, 64'h0);
            check("reset_busy", {63'h0, busy}, 64'h0);
            check("reset_done", {63'h0, done}, 64'h0);
        end

        // directed vector table
        for (int i = 0; i < NREC; i++) begin
            start = tbl[i].start;
            abort = tbl[i].abort;
            sel   = tbl[i].sel;
            mode  = tbl[i].mode;
            for (int c = 0; c < tbl[i].rep; c++) begin
                @(posedge clk); #1;
                start = 1'b0;
                abort = 1'b0;
                if (c < tbl[i].rep - 1) begin
                    check($sformatf("vec%0d_done_quiet", i), {63'h0, done}, 64'h0);
                end else begin
                    check($sformatf("vec%0d_busy", i), {63'h0, busy}, {63'h0, tbl[i].busy});
                    check($sformatf("vec%0d_done", i), {63'h0, done}, {63'h0, tbl[i].done});
                    check($sformatf("vec%0d_backg", i), bg, tbl[i].bg);
                    check($sformatf("vec%0d_point", i), pt, tbl[i].pt);
                end
            end
        end

        // blank pattern 7 with a normal hold/done cadence
        start = 1'b1; sel = 3'd7; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            check($sformatf("blank_k%0d_busy", k), {63'h0, busy}, {63'h0, (k <= 11)});
            check($sformatf("blank_k%0d_done", k), {63'h0, done}, {63'h0, (k == 12)});
            check($sformatf("blank_k%0d_backg", k), bg, 64'h0);
        end

        // asynchronous reset in the middle of a hold
        start = 1'b1; sel = 3'd5; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("trophy_backg", bg, rom_bg[5]);
        #2 rst = 1'b1;
        #1;
        check("async_rst_backg", bg, 64'h0);
        check("async_rst_point", pt, 64'h0);
        check("async_rst_busy", {63'h0, busy}, 64'h0);
        check("async_rst_done", {63'h0, done}, 64'h0);
        #2 rst = 1'b0;

        // randomized run against the timeline model
        ph = -1; e_bg = 64'h0; e_pt = 64'h0;
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 79) == 0);
            sel   = 3'($urandom_range(0, 7));
            mode  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            model_step(start, abort, int'(sel), mode);
            n_vec++;
            if ({bg, pt, busy, done} !== {e_bg, e_pt, e_busy, e_done}) begin
                n_bad++;
                if (n_print < 20) begin
                    n_print++;
                    $display("FAIL random cycle %0d: got bg=%h pt=%h busy=%0b done=%0b, expected bg=%h pt=%h busy=%0b done=%0b",
                             c, bg, pt, busy, done, e_bg, e_pt, e_busy, e_done);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
